// File: rtl/yarp_data_mem_if.sv
// Load/store unit: one req/gnt/rvalid bus transaction at a time, with pipeline stall and load formatting.
// Optional bus timeout abort is built when YARP_DMEM_TIMEOUT_EN is defined.
module yarp_data_mem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  input  logic        zero_extnd_i,
  output logic        stall_o,
  output logic        mem_rd_valid_o,
  output logic [31:0] mem_rd_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        aligned, accept, timeout, abort;
  logic [31:0] addr_p0, wdata_p0;
  logic [1:0]  size_p0;
  logic        we_p0, zext_p0;
  logic        vld_p1, misalign_p1;
  logic [31:0] rd_data_p1;

  // Size encoding 2'b10 falls into the word branch everywhere below.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wr_lanes(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   wr_lanes = {4{wd[7:0]}};
      2'b01:   wr_lanes = {2{wd[15:0]}};
      default: wr_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [1:0] sz, input logic [1:0] a,
                                           input logic zx, input logic [31:0] rd);
    logic        [31:0] lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rd >> {a, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (sz)
      2'b00:   fmt_load = zx ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = zx ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmt_load = rd;
    endcase
  endfunction

  assign aligned = is_aligned(data_byte_i, data_addr_i[1:0]);
  assign accept  = (state_q == IDLE) && data_req_i && aligned;
  assign stall_o = (state_q != IDLE) || accept;

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (bus_gnt_i) state_d = RESP;
        else if (timeout) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      RESP: begin
        if (bus_rvalid_i) state_d = IDLE;
        else if (timeout) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vld_p1      <= 1'b0;
      misalign_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_p1      <= (state_q == RESP) && bus_rvalid_i && !we_p0;
      misalign_p1 <= (state_q == IDLE) && data_req_i && !aligned;
    end
  end

  // p0: request captured at accept, held through REQ/RESP
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= data_addr_i;
      size_p0  <= data_byte_i;
      we_p0    <= data_wr_i;
      wdata_p0 <= wr_lanes(data_byte_i, data_wr_data_i);
      zext_p0  <= zero_extnd_i;
    end
  end

  // p1: formatted load data, registered on rvalid
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && bus_rvalid_i)
      rd_data_p1 <= fmt_load(size_p0, addr_p0[1:0], zext_p0, bus_rdata_i);
  end

  assign bus_req_o      = (state_q == REQ);
  assign bus_addr_o     = bus_req_o ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign bus_we_o       = bus_req_o && we_p0;
  assign bus_be_o       = bus_req_o ? byte_en(size_p0, addr_p0[1:0]) : 4'd0;
  assign bus_wdata_o    = bus_req_o ? wdata_p0 : 32'd0;
  assign mem_rd_valid_o = vld_p1;
  assign mem_rd_data_o  = vld_p1 ? rd_data_p1 : 32'd0;
  assign misalign_o     = misalign_p1;

`ifdef YARP_DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q;
  logic          err_p1;

  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  // Counter restarts on every state change, so REQ and RESP each get a full budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= abort;
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q != IDLE) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus_err_o = err_p1;
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign bus_err_o      = 1'b0;
  assign unused_timeout = ^{TIMEOUT, abort};
`endif

endmodule

// File: tb/tb_yarp_data_mem_if.sv
// Scoreboard bench for yarp_data_mem_if: directed loads/stores, misalign, stall, reset and (optional) timeout.
module tb_yarp_data_mem_if;

  localparam int TIMEOUT = 16;
  localparam logic [1:0] K_RD = 2'd0, K_MIS = 2'd1, K_ERR = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [1:0]  data_byte_i;
  logic        data_wr_i;
  logic [31:0] data_wr_data_i;
  logic        zero_extnd_i;
  logic        stall_o, mem_rd_valid_o, misalign_o, bus_err_o;
  logic [31:0] mem_rd_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  yarp_data_mem_if #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_i(data_byte_i),
    .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i), .zero_extnd_i(zero_extnd_i),
    .stall_o(stall_o), .mem_rd_valid_o(mem_rd_valid_o), .mem_rd_data_o(mem_rd_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_rd_valid_o || misalign_o || bus_err_o) begin
      logic [1:0] k;
      k = mem_rd_valid_o ? K_RD : (misalign_o ? K_MIS : K_ERR);
      if ((mem_rd_valid_o + misalign_o + bus_err_o) > 1) begin
        checks++;
        errors++;
        $display("FAIL evt_overlap: rd=%0b mis=%0b err=%0b", mem_rd_valid_o, misalign_o, bus_err_o);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: kind %0d data 0x%08h with empty scoreboard", k, mem_rd_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_kind", 32'(k), 32'(e.kind));
        if (e.kind == K_RD) chk("rd_data", mem_rd_data_o, e.data);
      end
    end
  end

  task automatic xfer(input string nm, input logic [1:0] sz, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wd, input logic zx,
                      input logic [31:0] rd, input int gdly, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd);
    data_req_i = 1'b1; data_addr_i = addr; data_byte_i = sz;
    data_wr_i = wr; data_wr_data_i = wd; zero_extnd_i = zx;
    #1 chk({nm, "_stall_acc"}, 32'(stall_o), 1);
    tick();
    data_req_i = 1'b0; data_addr_i = 32'hFFFF_FFFF; data_wr_data_i = 32'h5A5A_5A5A;
    for (int i = 0; i < gdly; i++) begin
      chk({nm, "_req_wait"}, 32'(bus_req_o), 1);
      chk({nm, "_addr_wait"}, bus_addr_o, addr & ~32'd3);
      tick();
    end
    chk({nm, "_req"}, 32'(bus_req_o), 1);
    chk({nm, "_addr"}, bus_addr_o, addr & ~32'd3);
    chk({nm, "_we"}, 32'(bus_we_o), 32'(wr));
    chk({nm, "_be"}, 32'(bus_be_o), 32'(ebe));
    if (wr) chk({nm, "_wdata"}, bus_wdata_o, ewd);
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    chk({nm, "_req_resp"}, 32'(bus_req_o), 0);
    chk({nm, "_stall_resp"}, 32'(stall_o), 1);
    bus_rvalid_i = 1'b1; bus_rdata_i = rd;
    if (!wr) sb.push_back('{K_RD, erd});
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    chk({nm, "_stall_done"}, 32'(stall_o), 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; data_req_i = 1'b0; data_addr_i = '0; data_byte_i = '0;
    data_wr_i = 1'b0; data_wr_data_i = '0; zero_extnd_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) tick();
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_valid", 32'(mem_rd_valid_o), 0);
    chk("rst_rdata", mem_rd_data_o, 0);
    chk("rst_misalign", 32'(misalign_o), 0);
    chk("rst_err", 32'(bus_err_o), 0);
    chk("rst_be", 32'(bus_be_o), 0);
    reset = 1'b0;
    tick();

    xfer("lw",   2'b11, 32'h100, 0, 32'h0,        0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    xfer("lb",   2'b00, 32'h103, 0, 32'h0,        0, 32'h80AA5511, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    xfer("lbu",  2'b00, 32'h103, 0, 32'h0,        1, 32'h80AA5511, 0, 4'b1000, 32'h0,        32'h00000080);
    xfer("lhu",  2'b01, 32'h102, 0, 32'h0,        1, 32'h80AA5511, 0, 4'b1100, 32'h0,        32'h000080AA);
    xfer("lh",   2'b01, 32'h102, 0, 32'h0,        0, 32'h80AA5511, 0, 4'b1100, 32'h0,        32'hFFFF80AA);
    xfer("lb1",  2'b00, 32'h101, 0, 32'h0,        0, 32'h80AA5511, 1, 4'b0010, 32'h0,        32'h00000055);
    xfer("sh",   2'b01, 32'h206, 1, 32'h1234ABCD, 0, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0);
    xfer("sb",   2'b00, 32'h201, 1, 32'h000000EE, 0, 32'h0,        2, 4'b0010, 32'hEEEEEEEE, 32'h0);
    xfer("lw10", 2'b10, 32'h104, 0, 32'h0,        0, 32'h01234567, 0, 4'b1111, 32'h0,        32'h01234567);
    xfer("lwgd", 2'b11, 32'h300, 0, 32'h0,        0, 32'hCAFEF00D, 5, 4'b1111, 32'h0,        32'hCAFEF00D);

    // Misaligned word and half: dropped with a pulse, no bus activity.
    data_req_i = 1'b1; data_addr_i = 32'h101; data_byte_i = 2'b11; data_wr_i = 1'b0;
    #1 chk("mis_w_stall", 32'(stall_o), 0);
    sb.push_back('{K_MIS, 32'h0});
    tick();
    data_req_i = 1'b0;
    chk("mis_w_req", 32'(bus_req_o), 0);
    tick();
    data_req_i = 1'b1; data_addr_i = 32'h203; data_byte_i = 2'b01; data_wr_i = 1'b1;
    #1 chk("mis_h_stall", 32'(stall_o), 0);
    sb.push_back('{K_MIS, 32'h0});
    tick();
    data_req_i = 1'b0;
    chk("mis_h_req", 32'(bus_req_o), 0);
    tick();

    // Reset in RESP abandons the load; a late rvalid in IDLE is ignored.
    data_req_i = 1'b1; data_addr_i = 32'h400; data_byte_i = 2'b11; data_wr_i = 1'b0;
    tick();
    data_req_i = 1'b0;
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_resp_req", 32'(bus_req_o), 0);
    chk("rst_resp_stall", 32'(stall_o), 0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    tick();
    bus_rvalid_i = 1'b0;
    chk("late_rvalid_stall", 32'(stall_o), 0);
    tick();

`ifdef YARP_DMEM_TIMEOUT_EN
    begin
      int n;
      data_req_i = 1'b1; data_addr_i = 32'h500; data_byte_i = 2'b11; data_wr_i = 1'b0;
      tick();
      data_req_i = 1'b0;
      sb.push_back('{K_ERR, 32'h0});
      n = 1;
      while (stall_o && n < 40) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 32'(TIMEOUT + 1));
      chk("to_stall", 32'(stall_o), 0);
      chk("to_req", 32'(bus_req_o), 0);
      tick();
    end
`endif

    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
